mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  CPU-side initiator for the data port (port 2) of the dual-port BRAM; sits between the pipeline MEM stage and memory.
//  Accepts one load/store per request; accesses within one word go through as one memory access.
//  Word-crossing accesses (sh @offset 3, sw @offset 1..3) are split into byte accesses, reassembled and sign/zero-extended.
//  Pipeline stalls while REQ_READY=0.
// PARAMETERS
//  IO_BASE  32'h11000000  first MMIO address; memory routes >=IO_BASE to IO; never split
// PORTS
//  CLK          in   1   single clock; all state updates on posedge
//  RST          in   1   synchronous, active-high reset
//  REQ_VALID    in   1   request present
//  REQ_READY    out  1   unit idle, request accepted when VALID&&READY
//  REQ_WE       in   1   1=store, 0=load
//  REQ_ADDR     in   32  byte address
//  REQ_WDATA    in   32  store data, LSB-justified
//  REQ_SIZE     in   2   0=byte 1=half 2=word 3=illegal
//  REQ_SIGN     in   1   1=zero-extend (lbu/lhu), 0=sign-extend
//  RSP_VALID    out  1   one-cycle completion pulse
//  RSP_RDATA    out  32  load result, valid with RSP_VALID (0 for stores)
//  RSP_ERR      out  1   request rejected, no memory access made
//  MEM_ADDR2    out  32  to memory data port
//  MEM_DIN2     out  32  store data, LSB-justified
//  MEM_WRITE2   out  1   write strobe
//  MEM_READ2    out  1   read strobe
//  MEM_SIZE     out  2   sub-access size
//  MEM_SIGN     out  1   sub-access extension
//  MEM_DOUT2    in   32  read data, valid exactly one cycle after MEM_READ2
// BEHAVIOUR
//  Reset: state IDLE; REQ_READY=0 while RST=1, 1 from next cycle. RSP_*, MEM_* all 0.
//  Classify at accept: nsub=1 if size0, size1 && off!=3, or size2 && off==0; else nsub=1<<size byte ops.
//  Error if: size==3; split && (ADDR>=IO_BASE || ADDR+bytes-1>=IO_BASE); ADDR+bytes-1 wraps past 2^32.
//  States: IDLE -> ISSUE (or RESP on error) -> [DRAIN, loads only] -> RESP -> IDLE.
//  IDLE: READY=1. Accept at T: latch request, cnt=0.
//  ISSUE: READY=0. One strobe per cycle, cycles T+1..T+nsub.
//   Sub k: ADDR=addr+k (mod 2^32). Single: SIZE/SIGN/DIN from request.
//   Split: SIZE=0, SIGN=1, DIN={24'b0,WDATA[8k+:8]}.
//  Load capture: capture MEM_DOUT2 the cycle after each read strobe.
//   Split: byte k -> rdata[8k+:8], then extend from bit 8*bytes-1 unless REQ_SIGN. Single: store DOUT2 as-is.
//  DRAIN: one cycle, captures last load byte. Stores skip DRAIN.
//  RESP: RSP_VALID=1 for exactly one cycle, then IDLE; READY rises next cycle (no back-to-back accept).
//  Latency T->RSP_VALID: store nsub+1, load nsub+2, error 1.
//   Cases: aligned sw 2, aligned lw 3, lw @+1 6.
//  MEM_READ2/MEM_WRITE2 only in ISSUE, never together, never for IO-region split or error requests.
//  REQ_* ignored when READY=0. Accepted request's fields are held internally; inputs may change after accept.
//  RST mid-op: IDLE next cycle, strobes 0. Partly written split store is not rolled back; no RSP_VALID.
// STRUCTURE
//  mem_pkg: mem_size_t enum {MEM_BYTE,MEM_HALF,MEM_WORD}, IO_BASE localparam, mau_state_t enum.
//  Sub-module mem_load_assembler: byte-lane merge + sign/zero extension (combinational). Rest in top FSM.
// TESTING
//  Aligned sw addr=0x100 data=0xDEADBEEF -> one write T+1, SIZE=2; RSP_VALID T+2; lw 0x100 -> 0xDEADBEEF at T+3.
//  sh 0x203 data=0xA5B6 -> byte writes 0x203=0xB6, 0x204=0xA5; lh 0x203 -> 0xFFFFA5B6; lhu -> 0x0000A5B6.
//  sw 0x301 data=0x11223344 -> 4 byte writes 0x301..0x304; lw 0x301 -> 0x11223344, RSP at T+6.
//  REQ_SIZE=3 or lw 0x11000001 -> RSP_ERR=1 at T+1, no MEM strobe; sw 0x11000000 -> single write.
//  RST during 2nd byte of split sw -> no further strobes, no RSP_VALID, READY=1 after RST drops.
//  REQ_VALID held high throughout -> READY low ISSUE..RESP; one RSP per accept; lb 0x7 reads byte lane 3.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, constants and access-classification helpers for the data-port
// memory access unit.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RESP
    } mau_state_t;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // True when the access cannot be served by one in-word memory access.
    function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
        return !((size == MEM_BYTE) ||
                 (size == MEM_HALF && off != 2'd3) ||
                 (size == MEM_WORD && off == 2'd0));
    endfunction

endpackage

// File: rtl/mem_load_assembler.sv
// Merges one returned byte into the load buffer and applies sign/zero
// extension for loads that were split into byte accesses.
module mem_load_assembler
    import mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [31:0] dout_i,
    input  logic [1:0]  lane_i,
    input  logic        split_i,
    input  logic [1:0]  size_i,
    input  logic        zext_i,
    output logic [31:0] merged_o,
    output logic [31:0] result_o
);

    // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        merged_o = dout_i;
        if (split_i) begin
            merged_o = raw_i;
            merged_o[{lane_i, 3'b000} +: 8] = dout_i[7:0];
        end

        result_o = merged_o;
        // Only split halves need extension; the upper lanes hold stale bytes.
        if (split_i && size_i == MEM_HALF) begin
            result_o = zext_i ? {16'h0000, merged_o[15:0]}
                              : {{16{merged_o[15]}}, merged_o[15:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the BRAM data port: accepts one load/store at a time,
// splits word-crossing accesses into byte accesses and reassembles load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] IO_BASE = mem_pkg::IO_BASE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    mau_state_t  state_q;
    logic        ready_q;
    logic        we_q, sign_q, split_q;
    logic [1:0]  size_q, last_q, cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic        cap_en_q;
    logic [1:0]  cap_lane_q;
    logic [31:0] raw_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] mem_addr_q, mem_din_q;
    logic        mem_write_q, mem_read_q, mem_sign_q;
    logic [1:0]  mem_size_q;

    logic [3:0]  req_bytes;
    logic [32:0] req_end;
    logic        req_split, req_err;
    logic [1:0]  req_last;

    always_comb begin
        req_bytes = size_bytes(REQ_SIZE);
        req_end   = {1'b0, REQ_ADDR} + 33'(req_bytes) - 33'd1;
        req_split = needs_split(REQ_SIZE, REQ_ADDR[1:0]);
        req_err   = (REQ_SIZE == 2'd3) || req_end[32] ||
                    (req_split && (REQ_ADDR >= IO_BASE || req_end[31:0] >= IO_BASE));
        req_last  = req_split ? 2'(req_bytes - 4'd1) : 2'd0;
    end

    // Sub-access drive: sub 0 straight from the request at accept, later subs from the held copy.
    logic        src_split, src_sign;
    logic [1:0]  src_size, sub_idx;
    logic [31:0] src_addr, src_wdata;
    logic [31:0] mem_addr_d, mem_din_d;
    logic [1:0]  mem_size_d;
    logic        mem_sign_d;

    always_comb begin
        if (state_q == S_IDLE) begin
            src_addr  = REQ_ADDR;
            src_wdata = REQ_WDATA;
            src_size  = REQ_SIZE;
            src_sign  = REQ_SIGN;
            src_split = req_split;
            sub_idx   = 2'd0;
        end else begin
            src_addr  = addr_q;
            src_wdata = wdata_q;
            src_size  = size_q;
            src_sign  = sign_q;
            src_split = split_q;
            sub_idx   = cnt_q + 2'd1;
        end
        mem_addr_d = src_addr + 32'(sub_idx);
        mem_din_d  = src_split ? {24'h000000, src_wdata[{sub_idx, 3'b000} +: 8]} : src_wdata;
        mem_size_d = src_split ? MEM_BYTE : src_size;
        mem_sign_d = src_split | src_sign;
    end

    logic [31:0] merged, result;

    mem_load_assembler u_asm (
        .raw_i    (raw_q),
        .dout_i   (MEM_DOUT2),
        .lane_i   (cap_lane_q),
        .split_i  (split_q),
        .size_i   (size_q),
        .zext_i   (sign_q),
        .merged_o (merged),
        .result_o (result)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            cnt_q       <= 2'd0;
            cap_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_sign_q  <= 1'b0;
            // NOTE: held request fields and the load buffer are written before use, so they carry no reset.
        end else begin
            cap_en_q    <= mem_read_q;
            cap_lane_q  <= cnt_q;
            if (cap_en_q) begin
                raw_q <= merged;
            end

            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_sign_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (REQ_VALID && ready_q) begin
                        ready_q <= 1'b0;
                        we_q    <= REQ_WE;
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WDATA;
                        size_q  <= REQ_SIZE;
                        sign_q  <= REQ_SIGN;
                        split_q <= req_split;
                        last_q  <= req_last;
                        cnt_q   <= 2'd0;
                        if (req_err) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_ISSUE;
                            mem_addr_q  <= mem_addr_d;
                            mem_din_q   <= mem_din_d;
                            mem_size_q  <= mem_size_d;
                            mem_sign_q  <= mem_sign_d;
                            mem_write_q <= REQ_WE;
                            mem_read_q  <= !REQ_WE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cnt_q == last_q) begin
                        state_q     <= we_q ? S_RESP : S_DRAIN;
                        rsp_valid_q <= we_q;
                    end else begin
                        cnt_q       <= cnt_q + 2'd1;
                        mem_addr_q  <= mem_addr_d;
                        mem_din_q   <= mem_din_d;
                        mem_size_q  <= mem_size_d;
                        mem_sign_q  <= mem_sign_d;
                        mem_write_q <= we_q;
                        mem_read_q  <= !we_q;
                    end
                end
                S_DRAIN: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= result;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign REQ_READY  = ready_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign RSP_ERR    = rsp_err_q;
    assign MEM_ADDR2  = mem_addr_q;
    assign MEM_DIN2   = mem_din_q;
    assign MEM_WRITE2 = mem_write_q;
    assign MEM_READ2  = mem_read_q;
    assign MEM_SIZE   = mem_size_q;
    assign MEM_SIGN   = mem_sign_q;

endmodule
